mips_mc_core: RTL
=================

Name: mips_mc_core

Overview:
- Multi-cycle MIPS core; successor to the single-cycle CPU top.
- Executes the same instruction subset: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop.
- Has one shared instruction/data memory port with a req/ready handshake, so memory may insert wait states.
- Contains its own FSM controller, 32x32 register file, ALU and extender; exposes a retire/writeback trace port for the testbench.

Parameters:
- PC_RESET, 32'h0000_3000: PC value after reset.
- TIMEOUT, 0: maximum wait cycles for mem_ready on one transaction before the core halts; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  32  byte address; always word-aligned when mem_req=1.
- mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
- mem_rdata  input  32  read data; sampled in the cycle where mem_req=1 and mem_ready=1.
- mem_ready  input  1  transaction completes in this cycle; ignored while mem_req=0.
- retire  output  1  one-cycle pulse when an instruction completes.
- retire_pc  output  32  PC of the retiring instruction; valid while retire=1.
- wb_en  output  1  register write in this cycle (never asserted for $0).
- wb_reg  output  5  destination register.
- wb_data  output  32  value written.
- halted  output  1  sticky; core stopped.

Behaviour:
- Reset, asynchronous:
  - State = FETCH, PC = PC_RESET, all GPRs = 0, IR = 0.
  - mem_req, mem_we, retire, wb_en, halted = 0; mem_addr, mem_wdata, retire_pc, wb_reg, wb_data = 0.
  - Reset asserted mid-transaction drops mem_req in the same cycle, combinationally from reset; the transaction is abandoned.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ready: IR <= mem_rdata, curPC <= PC, PC <= PC+4, go to DECODE.
- DECODE:
  - A <= GPR[rs], B <= GPR[rt].
  - Any opcode/funct outside the subset goes to HALT; nop (all-zero word, i.e. sll $0) is legal.
  - Otherwise go to EXEC.
- EXEC:
  - addu/subu: ALUOut <= A±B, wraps mod 2^32, no overflow trap; go to WB.
  - ori: A | zext(imm16); go to WB.
  - lui: {imm16,16'h0}; go to WB.
  - lw/sw: ALUOut <= A + sext(imm16). If ALUOut[1:0] != 0, go to HALT with no memory access; else go to MEM.
  - beq: if A==B, PC <= PC + (sext(imm16)<<2); retire; go to FETCH.
  - j: PC <= {PC[31:28], instr_index, 2'b00}; retire; go to FETCH.
  - jal: same target as j; ALUOut <= PC (already curPC+4); go to WB writing $31.
  - jr: PC <= A; retire; go to FETCH. Target is not alignment-checked here; a misaligned PC halts on its next FETCH.
  - nop: retire; go to FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B.
  - On mem_ready: sw retires and goes to FETCH; lw latches MDR <= mem_rdata and goes to WB.
- WB:
  - Destination: rd for addu/subu; rt for ori/lui/lw; $31 for jal.
  - Write-enable is suppressed when destination = $0. GPR[0] always reads 0.
  - wb_en/wb_reg/wb_data reflect the write in this cycle; retire=1; go to FETCH.
- FETCH alignment: if PC[1:0] != 0, go to HALT without asserting mem_req.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from first assertion until the cycle mem_ready is sampled high.
  - mem_req deasserts the following cycle, because the state has changed.
  - Zero-wait memory (ready in the same cycle as req) is legal.
- Timeout: with TIMEOUT=N>0, a wait counter clears at request start and increments on each cycle with req=1 and ready=0. Reaching N goes to HALT and drops mem_req.
- HALT: halted=1, no requests, terminal until reset.
- Latency with zero-wait memory, in cycles:
  - beq, j, jr, nop: 3.
  - addu, subu, ori, lui, jal, sw: 4.
  - lw: 5.
  - Each memory wait cycle adds 1.
- Register file: written on the clock edge in WB; the next instruction's DECODE sees the new value, since there is no overlap.

Test Plan:
- Reset, then program "ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2" with zero-wait memory → wb_data sequence 0x00001234, 0xABCD0000, 0xABCD1234; retire_pc 0x3000, 0x3004, 0x3008; fetches at cycles 0, 4, 8.
- "sw $3,4($0); lw $4,4($0)" with mem_ready delayed 2 cycles per transaction → sw write seen at addr 0x4 with data 0xABCD1234; wb_reg=4 and wb_data=0xABCD1234; lw takes 5+4 cycles; mem_addr/mem_wdata stable during the wait.
- "beq $1,$1,-1" at 0x3010 → next fetch at 0x3010 (loop); with unequal operands, next fetch at 0x3014. "jal 0x3100" at 0x3014 → $31=0x3018, next fetch at 0x3100. "jr $31" → next fetch at 0x3018.
- "addu $0,$1,$2" → wb_en=0, retire=1, GPR0 still reads 0. "subu $5,$0,$1" with $1=1 → 0xFFFFFFFF.
- Illegal opcode 0x3F, "lw $1,2($0)", and mem_ready stuck low with TIMEOUT=8 → each case ends with halted=1 and mem_req=0. The timeout halts on the 8th wait cycle; the bench checks mem_req stays 0 afterwards.
- Reset pulse asserted during a stalled FETCH → mem_req drops immediately; after release, fetch restarts at 0x3000 with all registers 0.

Source files
------------

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core (addu/subu/ori/lui/lw/sw/beq/j/jal/jr/nop) sharing one
// instruction/data memory port with a req/ready handshake and a retire trace.
module mips_mc_core #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, cur_pc_q, cur_pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] wait_q, wait_d;
  logic [31:0] gpr_q [32];

  logic        req, we, ret, wen;
  logic [31:0] addr, wdata, wdat, rf_a, rf_b, sext, br_off, ea;
  logic [4:0]  dest;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        is_addu, is_subu, is_jr, is_nop, is_ori, is_lui;
  logic        is_lw, is_sw, is_beq, is_j, is_jal, legal;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm   = ir_q[15:0];

  assign is_nop  = (ir_q == 32'h0);
  assign is_addu = (op == 6'h00) && (funct == 6'h21);
  assign is_subu = (op == 6'h00) && (funct == 6'h23);
  assign is_jr   = (op == 6'h00) && (funct == 6'h08);
  assign is_ori  = (op == 6'h0D);
  assign is_lui  = (op == 6'h0F);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);
  assign legal   = is_nop | is_addu | is_subu | is_jr | is_ori | is_lui |
                   is_lw | is_sw | is_beq | is_j | is_jal;

  assign sext   = {{16{imm[15]}}, imm};
  assign br_off = {{14{imm[15]}}, imm, 2'b00};
  assign ea     = a_q + sext;
  assign dest   = is_jal ? 5'd31 : ((is_addu | is_subu) ? rd : rt);
  assign rf_a   = (rs == 5'd0) ? 32'h0 : gpr_q[rs];
  assign rf_b   = (rt == 5'd0) ? 32'h0 : gpr_q[rt];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cur_pc_d = cur_pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    wait_d   = 32'h0;
    req      = 1'b0;
    we       = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    ret      = 1'b0;
    wen      = 1'b0;
    wdat     = 32'h0;
    case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
        end else begin
          req  = 1'b1;
          addr = pc_q;
          if (mem_ready) begin
            ir_d     = mem_rdata;
            cur_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        // pc_q already holds curPC+4 here, which is the base for beq/j/jal
        state_d = S_FETCH;
        if (is_addu) begin
          alu_d = a_q + b_q; state_d = S_WB;
        end else if (is_subu) begin
          alu_d = a_q - b_q; state_d = S_WB;
        end else if (is_ori) begin
          alu_d = a_q | {16'h0, imm}; state_d = S_WB;
        end else if (is_lui) begin
          alu_d = {imm, 16'h0}; state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_d   = ea;
          state_d = (ea[1:0] != 2'b00) ? S_HALT : S_MEM;
        end else if (is_beq) begin
          if (a_q == b_q) pc_d = pc_q + br_off;
          ret = 1'b1;
        end else if (is_j || is_jal) begin
          pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
          if (is_jal) begin
            alu_d = pc_q; state_d = S_WB;
          end else begin
            ret = 1'b1;
          end
        end else if (is_jr) begin
          pc_d = a_q; ret = 1'b1;
        end else begin
          ret = 1'b1;
        end
      end
      S_MEM: begin
        req   = 1'b1;
        we    = is_sw;
        addr  = alu_q;
        wdata = b_q;
        if (mem_ready) begin
          if (is_sw) begin
            ret = 1'b1; state_d = S_FETCH;
          end else begin
            mdr_d = mem_rdata; state_d = S_WB;
          end
        end
      end
      S_WB: begin
        ret     = 1'b1;
        wen     = (dest != 5'd0);
        wdat    = is_lw ? mdr_q : alu_q;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    if ((TIMEOUT != 0) && req && !mem_ready) begin
      wait_d = wait_q + 32'd1;
      if (wait_d == 32'(TIMEOUT)) state_d = S_HALT;
    end
  end

  // Reset gates the bus combinationally so an in-flight request vanishes at once.
  assign mem_req   = req & ~reset;
  assign mem_we    = we & ~reset;
  assign mem_addr  = reset ? 32'h0 : addr;
  assign mem_wdata = reset ? 32'h0 : wdata;
  assign retire    = ret;
  assign retire_pc = ret ? cur_pc_q : 32'h0;
  assign wb_en     = wen;
  assign wb_reg    = (state_q == S_WB) ? dest : 5'd0;
  assign wb_data   = wdat;
  assign halted    = (state_q == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      cur_pc_q <= 32'h0;
      ir_q     <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      alu_q    <= 32'h0;
      mdr_q    <= 32'h0;
      wait_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cur_pc_q <= cur_pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      wait_q   <= wait_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
    end else if (wen) begin
      gpr_q[dest] <= wdat;
    end
  end

endmodule
